// File: rtl/db_cmd_initiator_if.sv
// MCU debug port bundle: one-hot command strobes with a valid
// pulse going out, busy / read data / error coming back.
interface db_cmd_initiator_if;
  logic        valid;
  logic        pause;
  logic        resume;
  logic        reset;
  logic        reg_rd;
  logic        reg_wr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] addr;
  logic [31:0] d_in;
  logic [3:0]  mem_be;
  logic        mcu_busy;
  logic [31:0] d_rd;
  logic        error;

  modport master (
    output valid, pause, resume, reset,
    output reg_rd, reg_wr, mem_rd, mem_wr,
    output addr, d_in, mem_be,
    input  mcu_busy, d_rd, error
  );

  modport slave (
    input  valid, pause, resume, reset,
    input  reg_rd, reg_wr, mem_rd, mem_wr,
    input  addr, d_in, mem_be,
    output mcu_busy, d_rd, error
  );
endinterface

// File: rtl/db_cmd_initiator.sv
// UART packet to MCU debug command initiator.
// Define DB_PC_READ_EN to add opcode 8 (read program counter).
module db_cmd_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned RX_GAP_CYCLES  = 500000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  input  logic [31:0]        pc,
  db_cmd_initiator_if.master dbg
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(RX_GAP_CYCLES + 1);
  localparam logic [7:0] ST_OK  = 8'h00;
  localparam logic [7:0] ST_ERR = 8'hEE;

  typedef enum logic [2:0] {
    IDLE, RX_ADDR, RX_DATA, ISSUE,
    WAIT, TX_STAT, TX_DATA, PC_RD
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    op, be;
  logic [31:0]   addr_q, data_q, rdata;
  logic [7:0]    status, tx_data_q;
  logic          has_data, tx_start_q;
  logic [1:0]    cnt, txc;
  logic [TW-1:0] wcnt;
  logic [GW-1:0] gcnt;

  logic [3:0] code;
  logic       is_short, is_long, pc_op;
  logic       fire, gap_out, wait_out, active;
  logic       op_data, op_read;

  assign code     = rx_data[3:0];
  assign is_short = code >= 4'd1 && code <= 4'd3;
  assign is_long  = code >= 4'd4 && code <= 4'd7;
`ifdef DB_PC_READ_EN
  assign pc_op    = code == 4'd8;
`else
  assign pc_op    = 1'b0;
`endif
  assign op_data  = op == 4'd5 || op == 4'd7;
  assign op_read  = op == 4'd4 || op == 4'd6;
  // tx_busy is only trusted from the cycle after our own tx_start
  assign fire     = !tx_busy && !tx_start_q;
  assign gap_out  = gcnt == GW'(RX_GAP_CYCLES - 1);
  assign wait_out = wcnt == TW'(TIMEOUT_CYCLES - 1);
  assign active   = state == ISSUE || state == WAIT;

  assign dbg.valid  = state == ISSUE;
  assign dbg.pause  = active && op == 4'd1;
  assign dbg.resume = active && op == 4'd2;
  assign dbg.reset  = active && op == 4'd3;
  assign dbg.reg_rd = active && op == 4'd4;
  assign dbg.reg_wr = active && op == 4'd5;
  assign dbg.mem_rd = active && op == 4'd6;
  assign dbg.mem_wr = active && op == 4'd7;
  assign dbg.addr   = active ? addr_q : 32'h0;
  assign dbg.d_in   = active ? data_q : 32'h0;
  assign dbg.mem_be = active ? be : 4'h0;
  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:
        if (rx_valid) begin
          unique case (1'b1)
            is_short: state_nx = ISSUE;
            is_long:  state_nx = RX_ADDR;
            pc_op:    state_nx = PC_RD;
            default:  state_nx = TX_STAT;
          endcase
        end
      RX_ADDR:
        if (rx_valid) begin
          if (cnt == 2'd3)
            state_nx = op_data ? RX_DATA : ISSUE;
        end else if (gap_out) begin
          state_nx = IDLE;
        end
      RX_DATA:
        if (rx_valid) begin
          if (cnt == 2'd3) state_nx = ISSUE;
        end else if (gap_out) begin
          state_nx = IDLE;
        end
      ISSUE:
        state_nx = WAIT;
      WAIT:
        if (!dbg.mcu_busy || wait_out)
          state_nx = TX_STAT;
      TX_STAT:
        if (fire) state_nx = has_data ? TX_DATA : IDLE;
      TX_DATA:
        if (fire && txc == 2'd3) state_nx = IDLE;
      PC_RD:
        state_nx = TX_STAT;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op         <= '0;
      be         <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rdata      <= '0;
      status     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      has_data   <= 1'b0;
      cnt        <= '0;
      txc        <= '0;
      wcnt       <= '0;
      gcnt       <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (state)
        IDLE:
          if (rx_valid) begin
            op       <= code;
            addr_q   <= '0;
            data_q   <= '0;
            cnt      <= '0;
            gcnt     <= '0;
            has_data <= 1'b0;
            status   <= ST_ERR;
            if (code == 4'd6 || code == 4'd7)
              be <= (rx_data[7:4] == 4'h0) ? 4'hF : rx_data[7:4];
            else
              be <= 4'h0;
          end
        RX_ADDR:
          if (rx_valid) begin
            addr_q <= {addr_q[23:0], rx_data};
            cnt    <= cnt + 2'd1;
            gcnt   <= '0;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        RX_DATA:
          if (rx_valid) begin
            data_q <= {data_q[23:0], rx_data};
            cnt    <= cnt + 2'd1;
            gcnt   <= '0;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        ISSUE:
          wcnt <= '0;
        WAIT:
          if (!dbg.mcu_busy) begin
            rdata    <= dbg.d_rd;
            status   <= dbg.error ? ST_ERR : ST_OK;
            has_data <= !dbg.error && op_read;
          end else if (wait_out) begin
            status   <= ST_ERR;
            has_data <= 1'b0;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
        PC_RD: begin
          rdata    <= pc;
          status   <= ST_OK;
          has_data <= 1'b1;
        end
        TX_STAT:
          if (fire) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= status;
            txc        <= '0;
          end
        TX_DATA:
          if (fire) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= rdata[31:24];
            rdata      <= {rdata[23:0], 8'h00};
            txc        <= txc + 2'd1;
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_db_cmd_initiator.sv
// Bench for db_cmd_initiator: directed packets plus randomized
// packets scored against a packet-level reference model.
module tb_db_cmd_initiator;
  localparam int TO  = 50;
  localparam int GAP = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [31:0] pc = 32'h0;

  db_cmd_initiator_if dbg();

  db_cmd_initiator #(
    .TIMEOUT_CYCLES(TO),
    .RX_GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx_busy(tx_busy),
    .pc(pc),
    .dbg(dbg)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [6:0] strb;
  assign strb = {dbg.mem_wr, dbg.mem_rd, dbg.reg_wr, dbg.reg_rd,
                 dbg.reset, dbg.resume, dbg.pause};

  // monitor state
  logic [7:0]  txq[$];
  int          nvalid, strb_cyc, stab_err, coll;
  logic [6:0]  c_strb;
  logic [31:0] c_addr, c_din;
  logic [3:0]  c_be;

  // responder / uart knobs
  int          busy_len = 3;
  bit          stuck = 0;
  logic [31:0] rd_val = 32'h0;
  bit          err_val = 0;
  int          tx_len = 4;

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start === 1'b1) txq.push_back(tx_data);
      if (dbg.valid === 1'b1) begin
        nvalid++;
        c_strb = strb;
        c_addr = dbg.addr;
        c_din = dbg.d_in;
        c_be = dbg.mem_be;
        strb_cyc = 0;
      end
      if (strb !== 7'h0) begin
        strb_cyc++;
        if (strb !== c_strb || dbg.addr !== c_addr ||
            dbg.d_in !== c_din || dbg.mem_be !== c_be)
          stab_err++;
      end
    end
  end

  initial begin
    dbg.mcu_busy = 1'b0;
    dbg.d_rd = 32'h0;
    dbg.error = 1'b0;
    forever begin
      @(negedge clk);
      if (dbg.valid === 1'b1) begin
        dbg.mcu_busy = 1'b1;
        dbg.d_rd = $urandom;
        dbg.error = 1'($urandom);
        if (stuck) begin
          for (int i = 0; i < TO + 20 && strb !== 7'h0; i++)
            @(negedge clk);
        end else begin
          repeat (busy_len) @(negedge clk);
        end
        dbg.d_rd = rd_val;
        dbg.error = err_val;
        dbg.mcu_busy = 1'b0;
      end
    end
  end

  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        tx_busy = 1'b1;
        repeat (tx_len) begin
          @(negedge clk);
          if (tx_start === 1'b1) coll++;
        end
        tx_busy = 1'b0;
      end
    end
  end

  task automatic clr();
    txq.delete();
    nvalid = 0;
    strb_cyc = 0;
    stab_err = 0;
    coll = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data = 8'($urandom);
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic wait_tx(input int n, output bit ok);
    for (int i = 0; i < 3000 && txq.size() < n; i++)
      @(negedge clk);
    ok = txq.size() >= n;
    repeat (40) @(negedge clk);
  endtask

  function automatic void model(
    input  logic [7:0]  p[$],
    input  bit          stk,
    input  bit          er,
    input  logic [31:0] rd,
    input  logic [31:0] pcv,
    output bit          iss,
    output logic [6:0]  s,
    output logic [31:0] a,
    output logic [31:0] d,
    output logic [3:0]  be,
    output logic [7:0]  tx[$]
  );
    int c = int'(p[0][3:0]);
    iss = 0; s = 0; a = 0; d = 0; be = 0;
    tx.delete();
    if (c >= 1 && c <= 7) begin
      iss = 1;
      s = 7'(1 << (c - 1));
      if (c >= 4) a = {p[1], p[2], p[3], p[4]};
      if (c == 5 || c == 7) d = {p[5], p[6], p[7], p[8]};
      if (c >= 6) be = (p[0][7:4] == 4'h0) ? 4'hF : p[0][7:4];
      if (stk || er) tx.push_back(8'hEE);
      else begin
        tx.push_back(8'h00);
        if (c == 4 || c == 6)
          for (int i = 3; i >= 0; i--) tx.push_back(8'(rd >> (8 * i)));
      end
    end
`ifdef DB_PC_READ_EN
    else if (c == 8) begin
      tx.push_back(8'h00);
      for (int i = 3; i >= 0; i--) tx.push_back(8'(pcv >> (8 * i)));
    end
`endif
    else tx.push_back(8'hEE);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({dbg.valid, strb, dbg.addr, dbg.d_in, dbg.mem_be} !== 76'h0) begin
      fails++;
      $display("FAIL reset_cmd valid=%b strb=%b addr=%h din=%h be=%h want all 0",
               dbg.valid, strb, dbg.addr, dbg.d_in, dbg.mem_be);
    end
    tests++;
    if ({tx_start, tx_data} !== 9'h0) begin
      fails++;
      $display("FAIL reset_tx tx_start=%b tx_data=%h want 0", tx_start, tx_data);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_pause();
    bit ok;
    logic [7:0] exp[$];
    exp = {8'h00};
    clr();
    busy_len = 10;
    send_byte(8'h01);
    send_byte(8'h02);
    wait_tx(1, ok);
    tests++;
    if (nvalid != 1 || c_strb !== 7'b0000001) begin
      fails++;
      $display("FAIL pause_cmd nvalid=%0d strb=%b want 1 / 0000001", nvalid, c_strb);
    end
    tests++;
    if (strb_cyc != 11) begin
      fails++;
      $display("FAIL pause_hold cycles=%0d want 11", strb_cyc);
    end
    tests++;
    if (!ok || txq != exp) begin
      fails++;
      $display("FAIL pause_tx got %p want %p", txq, exp);
    end
    busy_len = 3;
  endtask

  task automatic test_reg_rd();
    bit ok;
    logic [7:0] exp[$];
    exp = {8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    clr();
    rd_val = 32'hDEADBEEF;
    busy_len = $urandom_range(1, 8);
    send_byte(8'h04); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h05);
    wait_tx(5, ok);
    tests++;
    if (nvalid != 1 || {c_strb, c_addr, c_din, c_be} !==
        {7'b0001000, 32'h5, 32'h0, 4'h0}) begin
      fails++;
      $display("FAIL regrd_cmd strb=%b addr=%h din=%h be=%h want 0001000/5/0/0",
               c_strb, c_addr, c_din, c_be);
    end
    tests++;
    if (!ok || txq != exp || coll != 0) begin
      fails++;
      $display("FAIL regrd_tx got %p coll=%0d want %p", txq, coll, exp);
    end
  endtask

  task automatic test_mem_wr();
    bit ok;
    logic [7:0] pk[$];
    logic [7:0] exp[$];
    pk = {8'h37, 8'h00, 8'h00, 8'h00, 8'h10, 8'h11, 8'h22, 8'h33, 8'h44};
    exp = {8'h00};
    clr();
    foreach (pk[i]) send_byte(pk[i]);
    wait_tx(1, ok);
    tests++;
    if (nvalid != 1 || {c_strb, c_addr, c_din, c_be} !==
        {7'b1000000, 32'h10, 32'h11223344, 4'b0011}) begin
      fails++;
      $display("FAIL memwr_cmd strb=%b addr=%h din=%h be=%b want 1000000/10/11223344/0011",
               c_strb, c_addr, c_din, c_be);
    end
    tests++;
    if (!ok || txq != exp || stab_err != 0) begin
      fails++;
      $display("FAIL memwr_tx got %p stab=%0d want %p", txq, stab_err, exp);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    logic [7:0] exp[$];
    exp = {8'hEE};
    clr();
    stuck = 1;
    send_byte(8'h06); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h00);
    wait_tx(1, ok);
    stuck = 0;
    tests++;
    if (strb_cyc != TO + 1 || c_be !== 4'hF || c_strb !== 7'b0100000) begin
      fails++;
      $display("FAIL timeout_hold cycles=%0d be=%h strb=%b want %0d/f/0100000",
               strb_cyc, c_be, c_strb, TO + 1);
    end
    tests++;
    if (!ok || txq != exp) begin
      fails++;
      $display("FAIL timeout_tx got %p want %p", txq, exp);
    end
  endtask

  task automatic test_rx_gap();
    bit ok;
    logic [7:0] exp[$];
    exp = {8'h00};
    clr();
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
    repeat (GAP + 20) @(negedge clk);
    tests++;
    if (nvalid != 0 || txq.size() != 0) begin
      fails++;
      $display("FAIL gap_discard nvalid=%0d txbytes=%0d want 0/0", nvalid, txq.size());
    end
    send_byte(8'h02);
    wait_tx(1, ok);
    tests++;
    if (nvalid != 1 || c_strb !== 7'b0000010 || !ok || txq != exp) begin
      fails++;
      $display("FAIL gap_next nvalid=%0d strb=%b tx=%p want 1/0000010/%p",
               nvalid, c_strb, txq, exp);
    end
    // a pause just under the limit must not discard the packet
    clr();
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
    repeat (GAP - 8) @(negedge clk);
    send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_tx(1, ok);
    tests++;
    if (nvalid != 1 || {c_strb, c_addr, c_din} !==
        {7'b0010000, 32'h0, 32'h01020304} || !ok || txq != exp) begin
      fails++;
      $display("FAIL gap_edge nvalid=%0d strb=%b addr=%h din=%h tx=%p want 1/0010000/0/01020304",
               nvalid, c_strb, c_addr, c_din, txq);
    end
  endtask

  task automatic test_unknown();
    bit ok;
    logic [7:0] exp[$];
    exp = {8'hEE};
    clr();
    send_byte(8'h09);
    wait_tx(1, ok);
    tests++;
    if (nvalid != 0 || !ok || txq != exp) begin
      fails++;
      $display("FAIL unknown_9 nvalid=%0d tx=%p want 0/%p", nvalid, txq, exp);
    end
    clr();
    send_byte(8'h70);
    wait_tx(1, ok);
    tests++;
    if (nvalid != 0 || !ok || txq != exp) begin
      fails++;
      $display("FAIL unknown_0 nvalid=%0d tx=%p want 0/%p", nvalid, txq, exp);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      bit          ok, iss;
      int          k;
      logic [3:0]  lo;
      logic [7:0]  pk[$];
      logic [7:0]  exp[$];
      logic [6:0]  e_s;
      logic [31:0] e_a, e_d, a, d;
      logic [3:0]  e_be;
      k = $urandom_range(0, 9);
      lo = (k <= 6) ? 4'(k + 1) : (k == 7) ? 4'd8 :
           (k == 8) ? 4'd0 : 4'($urandom_range(9, 15));
      a = $urandom;
      d = $urandom;
      pk = {{4'($urandom), lo}};
      if (lo >= 4'd4 && lo <= 4'd7)
        for (int i = 3; i >= 0; i--) pk.push_back(8'(a >> (8 * i)));
      if (lo == 4'd5 || lo == 4'd7)
        for (int i = 3; i >= 0; i--) pk.push_back(8'(d >> (8 * i)));
      stuck = ($urandom_range(0, 7) == 0);
      err_val = ($urandom_range(0, 3) == 0);
      rd_val = $urandom;
      busy_len = $urandom_range(1, 8);
      tx_len = $urandom_range(1, 12);
      pc = $urandom;
      model(pk, stuck, err_val, rd_val, pc, iss, e_s, e_a, e_d, e_be, exp);
      clr();
      foreach (pk[i]) send_byte(pk[i]);
      wait_tx(exp.size(), ok);
      tests++;
      if (nvalid != int'(iss) ||
          (iss && {c_strb, c_addr, c_din, c_be} !== {e_s, e_a, e_d, e_be})) begin
        fails++;
        $display("FAIL rand_cmd it=%0d op=%h nvalid=%0d strb=%b addr=%h din=%h be=%h want %0d/%b/%h/%h/%h",
                 it, pk[0], nvalid, c_strb, c_addr, c_din, c_be,
                 iss, e_s, e_a, e_d, e_be);
      end
      tests++;
      if (!ok || txq != exp || stab_err != 0 || coll != 0) begin
        fails++;
        $display("FAIL rand_tx it=%0d op=%h got %p stab=%0d coll=%0d want %p",
                 it, pk[0], txq, stab_err, coll, exp);
      end
    end
    stuck = 0;
    tx_len = 4;
    busy_len = 3;
  endtask

  task automatic test_reset_mid();
    logic [7:0] pk[$];
    pk = {8'h05, 8'h00, 8'h00, 8'h01, 8'h00, 8'hA5, 8'h5A, 8'hC3, 8'h3C};
    clr();
    stuck = 1;
    foreach (pk[i]) send_byte(pk[i]);
    for (int i = 0; i < 200 && nvalid == 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    tests++;
    if (nvalid != 1 || strb !== 7'b0010000) begin
      fails++;
      $display("FAIL rstmid_wait nvalid=%0d strb=%b want 1/0010000", nvalid, strb);
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({dbg.valid, strb, tx_start, dbg.addr, dbg.d_in, dbg.mem_be} !== 77'h0) begin
      fails++;
      $display("FAIL rstmid_clear valid=%b strb=%b tx_start=%b addr=%h want all 0",
               dbg.valid, strb, tx_start, dbg.addr);
    end
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    stuck = 0;
    tests++;
    if (txq.size() != 0) begin
      fails++;
      $display("FAIL rstmid_tx bytes=%0d want 0", txq.size());
    end
  endtask

`ifdef DB_PC_READ_EN
  task automatic test_pc_read();
    bit ok;
    logic [7:0] exp[$];
    exp = {8'h00, 8'h00, 8'h00, 8'h00, 8'h14};
    clr();
    pc = 32'h14;
    send_byte(8'h08);
    wait_tx(5, ok);
    tests++;
    if (nvalid != 0 || !ok || txq != exp) begin
      fails++;
      $display("FAIL pc_read nvalid=%0d got %p want 0/%p", nvalid, txq, exp);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    test_reset();
    test_pause();
    test_reg_rd();
    test_mem_wr();
    test_timeout();
    test_rx_gap();
    test_unknown();
    test_reset_mid();
`ifdef DB_PC_READ_EN
    test_pc_read();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/db_cmd_initiator.md
Name: db_cmd_initiator

Overview:
- Host-facing initiator for the MCU debug handshake: assembles command packets from UART RX bytes, drives one-hot command strobes with a one-cycle valid pulse, waits out mcu_busy, and returns status/read data as UART TX bytes.
- Sits between uart_rx/uart_tx and the MCU's debug port.
- Is the command-issuing end of the valid/busy/d_rd protocol.

Parameters:
- TIMEOUT_CYCLES, 1000000: max cycles spent in WAIT before aborting with error status.
- RX_GAP_CYCLES, 500000: max idle cycles between bytes of one packet before the partial packet is discarded.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- rx_data  input  8  received byte
- rx_valid  input  1  one-cycle strobe, rx_data valid
- tx_data  output  8  byte to transmit
- tx_start  output  1  one-cycle strobe, load tx_data
- tx_busy  input  1  transmitter busy; tx_start only issued when low
- mcu_busy  input  1  responder busy; may rise combinationally with valid
- d_rd  input  32  read data from responder, sampled when mcu_busy low
- error  input  1  responder error, sampled with d_rd
- pc  input  32  current program counter
- addr, d_in  output  32 each  command address / write data
- pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr  output  1 each  one-hot command strobes
- mem_be  output  4  byte enables for mem ops
- valid  output  1  one-cycle command launch pulse

Behaviour:
- Reset: all outputs 0; state IDLE; byte counters 0.
- Packet format: opcode byte, then addr (4 bytes, MSB first) for codes 4-7, then data (4 bytes, MSB first) for codes 5 and 7.
  - opcode[3:0]: 1 pause, 2 resume, 3 reset, 4 reg_rd, 5 reg_wr, 6 mem_rd, 7 mem_wr.
  - opcode[7:4] = mem_be for codes 6/7; nibble 0 means 4'b1111; ignored (mem_be=0) otherwise.
- States: IDLE -> RX_ADDR -> RX_DATA -> ISSUE -> WAIT -> TX_STAT -> TX_DATA -> IDLE. Unused states are skipped per opcode.
- Unknown opcode in IDLE: go directly to TX_STAT with status 0xEE; no MCU command issued.
- ISSUE lasts exactly 1 cycle:
  - valid=1, the selected strobe=1, addr/d_in/mem_be driven.
  - Strobes, addr, d_in and mem_be are held stable until the state leaves WAIT; valid is 0 in every other cycle.
- WAIT:
  - The first eligible cycle is the one after ISSUE.
  - Leave when mcu_busy==0: latch d_rd and error, clear strobes.
  - Status 0x00 if error==0, else 0xEE.
  - After TIMEOUT_CYCLES cycles in WAIT: clear strobes, status 0xEE, d_rd not latched.
- TX_STAT: wait for tx_busy==0, pulse tx_start with the status byte for 1 cycle.
- TX_DATA:
  - Only for reg_rd/mem_rd with status 0x00.
  - Send the 4 latched bytes MSB first, each gated on tx_busy==0.
  - tx_busy is sampled no earlier than the cycle after the previous tx_start.
- RX_GAP: in RX_ADDR/RX_DATA, RX_GAP_CYCLES cycles without rx_valid -> discard the packet, return to IDLE, no response.
- rx_valid outside IDLE/RX_ADDR/RX_DATA: byte dropped; no queueing.
- Reset mid-operation: immediate return to IDLE with all outputs 0, including strobes during WAIT and an in-progress response.
- Byte assembly: shift-left by 8, new byte into [7:0]; counter 0..3, wraps only by state change.

Optional Feature:
- Macro DB_PC_READ_EN.
- Defined: opcode[3:0]=8 takes no address or data bytes and issues no MCU handshake. It latches pc in the cycle after the opcode byte and responds 0x00 followed by pc as 4 bytes MSB first.
- Undefined: code 8 is unknown and responds 0xEE only.

Test Plan:
- Bytes 0x01 -> one valid pulse with pause=1; responder holds mcu_busy 10 cycles; response 0x00; pause cleared the cycle mcu_busy is seen low.
- Bytes 0x04,00,00,00,05; responder returns d_rd=0xDEADBEEF -> reg_rd issued with addr=5; TX sequence 0x00,DE,AD,BE,EF.
- Bytes 0x37,00,00,00,10,11,22,33,44 -> mem_wr, mem_be=4'b0011, addr=0x10, d_in=0x11223344; response 0x00 only.
- Bytes 0x06,00,00,00,00 with mcu_busy stuck high and TIMEOUT_CYCLES=50 -> strobes drop after 50 WAIT cycles; response 0xEE only.
- Bytes 0x05,00,00 then silence with RX_GAP_CYCLES=100 -> no valid pulse, no TX; next 0x02 is handled normally (response 0x00).
- rst_n low during WAIT of reg_wr -> next cycle all strobes/valid/tx_start 0; with DB_PC_READ_EN, pc=0x14 and byte 0x08 -> TX 0x00,00,00,00,14.
